// File: rtl/boot_bus_sequencer_if.sv
// rtl/boot_bus_sequencer_if.sv - shared boot bus, copier/CPU/external requester signal bundle
interface boot_bus_sequencer_if;
    logic        copier_reset_n;
    logic        copier_done;
    logic [15:0] copier_address;
    logic        copier_ram_we_n;
    logic        copier_ram_cs_n;
    logic        copier_eeprom_oe_n;
    logic        copier_eeprom_cs_n;

    logic        cpu_reset_n;
    logic        cpu_busreq_n;
    logic        cpu_busack_n;
    logic [15:0] cpu_address;
    logic        cpu_ram_we_n;
    logic        cpu_ram_cs_n;

    logic        ext_req;
    logic        ext_grant;
    logic [15:0] ext_address;
    logic        ext_ram_we_n;
    logic        ext_ram_cs_n;

    logic [15:0] address;
    logic        ram_we_n;
    logic        ram_cs_n;
    logic        eeprom_oe_n;
    logic        eeprom_cs_n;
    logic [1:0]  owner;
    logic        boot_done;
    logic        fault;

    modport master (
        output copier_reset_n,
        input  copier_done, copier_address, copier_ram_we_n, copier_ram_cs_n,
        input  copier_eeprom_oe_n, copier_eeprom_cs_n,
        output cpu_reset_n, cpu_busreq_n,
        input  cpu_busack_n, cpu_address, cpu_ram_we_n, cpu_ram_cs_n,
        input  ext_req,
        output ext_grant,
        input  ext_address, ext_ram_we_n, ext_ram_cs_n,
        output address, ram_we_n, ram_cs_n, eeprom_oe_n, eeprom_cs_n,
        output owner, boot_done, fault
    );

    modport slave (
        input  copier_reset_n,
        output copier_done, copier_address, copier_ram_we_n, copier_ram_cs_n,
        output copier_eeprom_oe_n, copier_eeprom_cs_n,
        input  cpu_reset_n, cpu_busreq_n,
        output cpu_busack_n, cpu_address, cpu_ram_we_n, cpu_ram_cs_n,
        output ext_req,
        input  ext_grant,
        output ext_address, ext_ram_we_n, ext_ram_cs_n,
        input  address, ram_we_n, ram_cs_n, eeprom_oe_n, eeprom_cs_n,
        input  owner, boot_done, fault
    );
endinterface

// File: rtl/boot_bus_sequencer.sv
// rtl/boot_bus_sequencer.sv - boot sequencing (copy, settle, CPU release) and run-mode bus arbitration
module boot_bus_sequencer #(
    parameter int CPU_RESET_DELAY = 16,
    parameter int COPY_TIMEOUT    = 40000
) (
    input  logic                   clock,
    input  logic                   reset,
    boot_bus_sequencer_if.master   bus
);

    localparam int DW = (CPU_RESET_DELAY < 1) ? 1 : $clog2(CPU_RESET_DELAY + 1);
    localparam int TW = (COPY_TIMEOUT < 1) ? 1 : $clog2(COPY_TIMEOUT + 1);
    localparam logic [DW-1:0] DELAY_LOAD   = DW'(CPU_RESET_DELAY);
    localparam logic [DW-1:0] DELAY_LAST   = DW'(1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(COPY_TIMEOUT - 1);
    localparam logic [TW-1:0] TCNT_MAX     = '1;

    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_COPIER = 2'd1;
    localparam logic [1:0] OWN_CPU    = 2'd2;
    localparam logic [1:0] OWN_EXT    = 2'd3;

    typedef enum logic [2:0] {
        S_HOLD, S_COPY, S_HANDOFF, S_RUN, S_BUSREQ, S_EXT, S_RELEASE, S_FAULT
    } state_t;

    state_t        state;
    logic [DW-1:0] delay_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          copier_reset_n_r;
    logic          cpu_reset_n_r;
    logic          cpu_busreq_n_r;
    logic          ext_grant_r;
    logic [1:0]    owner_r;
    logic          boot_done_r;
    logic          fault_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_HOLD;
            delay_cnt        <= '0;
            timeout_cnt      <= '0;
            copier_reset_n_r <= 1'b0;
            cpu_reset_n_r    <= 1'b0;
            cpu_busreq_n_r   <= 1'b1;
            ext_grant_r      <= 1'b0;
            owner_r          <= OWN_NONE;
            boot_done_r      <= 1'b0;
            fault_r          <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    state            <= S_COPY;
                    copier_reset_n_r <= 1'b1;
                    owner_r          <= OWN_COPIER;
                    timeout_cnt      <= '0;
                end
                S_COPY: begin
                    // done wins over a timeout landing on the same cycle
                    if (bus.copier_done) begin
                        state     <= S_HANDOFF;
                        owner_r   <= OWN_NONE;
                        delay_cnt <= DELAY_LOAD;
                    end else if (COPY_TIMEOUT != 0 && timeout_cnt == TIMEOUT_LAST) begin
                        state            <= S_FAULT;
                        owner_r          <= OWN_NONE;
                        copier_reset_n_r <= 1'b0;
                        fault_r          <= 1'b1;
                    end else if (timeout_cnt != TCNT_MAX) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                S_HANDOFF: begin
                    if (delay_cnt == DELAY_LAST) begin
                        state         <= S_RUN;
                        cpu_reset_n_r <= 1'b1;
                        boot_done_r   <= 1'b1;
                        owner_r       <= OWN_CPU;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.ext_req) begin
                        state          <= S_BUSREQ;
                        cpu_busreq_n_r <= 1'b0;
                    end
                end
                S_BUSREQ: begin
                    if (!bus.ext_req) begin
                        state          <= S_RELEASE;
                        cpu_busreq_n_r <= 1'b1;
                        owner_r        <= OWN_NONE;
                    end else if (!bus.cpu_busack_n) begin
                        state       <= S_EXT;
                        ext_grant_r <= 1'b1;
                        owner_r     <= OWN_EXT;
                    end
                end
                S_EXT: begin
                    if (!bus.ext_req) begin
                        state          <= S_RELEASE;
                        ext_grant_r    <= 1'b0;
                        cpu_busreq_n_r <= 1'b1;
                        owner_r        <= OWN_NONE;
                    end
                end
                S_RELEASE: begin
                    // CPU keeps the bus tristated until it drops its acknowledge
                    if (bus.cpu_busack_n) begin
                        state   <= S_RUN;
                        owner_r <= OWN_CPU;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: state <= S_HOLD;
            endcase
        end
    end

    assign bus.copier_reset_n = copier_reset_n_r;
    assign bus.cpu_reset_n    = cpu_reset_n_r;
    assign bus.cpu_busreq_n   = cpu_busreq_n_r;
    assign bus.ext_grant      = ext_grant_r;
    assign bus.owner          = owner_r;
    assign bus.boot_done      = boot_done_r;
    assign bus.fault          = fault_r;

    always_comb begin
        bus.address     = 16'h0000;
        bus.ram_we_n    = 1'b1;
        bus.ram_cs_n    = 1'b1;
        bus.eeprom_oe_n = 1'b1;
        bus.eeprom_cs_n = 1'b1;
        case (owner_r)
            OWN_COPIER: begin
                bus.address     = bus.copier_address;
                bus.ram_we_n    = bus.copier_ram_we_n;
                bus.ram_cs_n    = bus.copier_ram_cs_n;
                bus.eeprom_oe_n = bus.copier_eeprom_oe_n;
                bus.eeprom_cs_n = bus.copier_eeprom_cs_n;
            end
            OWN_CPU: begin
                bus.address  = bus.cpu_address;
                bus.ram_we_n = bus.cpu_ram_we_n;
                bus.ram_cs_n = bus.cpu_ram_cs_n;
            end
            OWN_EXT: begin
                bus.address  = bus.ext_address;
                bus.ram_we_n = bus.ext_ram_we_n;
                bus.ram_cs_n = bus.ext_ram_cs_n;
            end
            default: begin
                bus.address = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_bus_sequencer.sv
// tb/tb_boot_bus_sequencer.sv - directed scoreboard bench for boot_bus_sequencer
module tb_boot_bus_sequencer;

    logic clock = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic reset_c = 1'b1;

    always #5 clock = ~clock;

    boot_bus_sequencer_if bif_a ();
    boot_bus_sequencer_if bif_b ();
    boot_bus_sequencer_if bif_c ();

    boot_bus_sequencer #(.CPU_RESET_DELAY(4), .COPY_TIMEOUT(40000)) dut_a (
        .clock(clock), .reset(reset_a), .bus(bif_a.master));
    boot_bus_sequencer #(.CPU_RESET_DELAY(4), .COPY_TIMEOUT(50)) dut_b (
        .clock(clock), .reset(reset_b), .bus(bif_b.master));
    boot_bus_sequencer #(.CPU_RESET_DELAY(4), .COPY_TIMEOUT(0)) dut_c (
        .clock(clock), .reset(reset_c), .bus(bif_c.master));

    int checks = 0;
    int errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
        end
        if (exp_q.size() != 0) begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    initial begin
        #600000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        bit  any_fault;

        bif_a.copier_done = 0; bif_a.copier_address = 0; bif_a.copier_ram_we_n = 1;
        bif_a.copier_ram_cs_n = 1; bif_a.copier_eeprom_oe_n = 1; bif_a.copier_eeprom_cs_n = 1;
        bif_a.cpu_busack_n = 1; bif_a.cpu_address = 0; bif_a.cpu_ram_we_n = 1; bif_a.cpu_ram_cs_n = 1;
        bif_a.ext_req = 0; bif_a.ext_address = 0; bif_a.ext_ram_we_n = 1; bif_a.ext_ram_cs_n = 1;
        bif_b.copier_done = 0; bif_b.copier_address = 16'h5555; bif_b.copier_ram_we_n = 1;
        bif_b.copier_ram_cs_n = 1; bif_b.copier_eeprom_oe_n = 0; bif_b.copier_eeprom_cs_n = 0;
        bif_b.cpu_busack_n = 1; bif_b.cpu_address = 0; bif_b.cpu_ram_we_n = 1; bif_b.cpu_ram_cs_n = 1;
        bif_b.ext_req = 0; bif_b.ext_address = 0; bif_b.ext_ram_we_n = 1; bif_b.ext_ram_cs_n = 1;
        bif_c.copier_done = 0; bif_c.copier_address = 0; bif_c.copier_ram_we_n = 1;
        bif_c.copier_ram_cs_n = 1; bif_c.copier_eeprom_oe_n = 1; bif_c.copier_eeprom_cs_n = 1;
        bif_c.cpu_busack_n = 1; bif_c.cpu_address = 0; bif_c.cpu_ram_we_n = 1; bif_c.cpu_ram_cs_n = 1;
        bif_c.ext_req = 0; bif_c.ext_address = 0; bif_c.ext_ram_we_n = 1; bif_c.ext_ram_cs_n = 1;

        // reset state; copier inputs active and ext_req high must not reach the bus
        bif_a.ext_req = 1;
        bif_a.copier_address = 16'hE123; bif_a.copier_ram_we_n = 0;
        bif_a.copier_eeprom_cs_n = 0; bif_a.copier_eeprom_oe_n = 0;
        tick(); tick();
        expect_val("rst_copier_reset_n", 0); observe(bif_a.copier_reset_n);
        expect_val("rst_cpu_reset_n", 0);    observe(bif_a.cpu_reset_n);
        expect_val("rst_cpu_busreq_n", 1);   observe(bif_a.cpu_busreq_n);
        expect_val("rst_ext_grant", 0);      observe(bif_a.ext_grant);
        expect_val("rst_owner", 0);          observe(bif_a.owner);
        expect_val("rst_boot_done", 0);      observe(bif_a.boot_done);
        expect_val("rst_fault", 0);          observe(bif_a.fault);
        expect_val("rst_address", 0);        observe(bif_a.address);
        expect_val("rst_ram_we_n", 1);       observe(bif_a.ram_we_n);
        expect_val("rst_eeprom_cs_n", 1);    observe(bif_a.eeprom_cs_n);

        reset_a = 0;
        tick();
        expect_val("copy_owner", 1);          observe(bif_a.owner);
        expect_val("copy_copier_reset_n", 1); observe(bif_a.copier_reset_n);
        expect_val("copy_address", 16'hE123); observe(bif_a.address);
        expect_val("copy_ram_we_n", 0);       observe(bif_a.ram_we_n);
        expect_val("copy_eeprom_cs_n", 0);    observe(bif_a.eeprom_cs_n);
        expect_val("copy_eeprom_oe_n", 0);    observe(bif_a.eeprom_oe_n);
        for (int i = 0; i < 97; i++) begin
            tick();
            expect_val("copy_loop_owner", 1);     observe(bif_a.owner);
            expect_val("copy_loop_ext_grant", 0); observe(bif_a.ext_grant);
            expect_val("copy_loop_busreq_n", 1);  observe(bif_a.cpu_busreq_n);
        end

        bif_a.copier_done = 1;
        bif_a.ext_req = 0;
        tick();
        bif_a.copier_done = 0;
        expect_val("handoff_owner", 0);       observe(bif_a.owner);
        expect_val("handoff_address", 0);     observe(bif_a.address);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_val("handoff_cpu_reset_n", 0); observe(bif_a.cpu_reset_n);
            expect_val("handoff_loop_owner", 0);  observe(bif_a.owner);
        end
        tick();
        expect_val("run_cpu_reset_n", 1); observe(bif_a.cpu_reset_n);
        expect_val("run_boot_done", 1);   observe(bif_a.boot_done);
        expect_val("run_owner", 2);       observe(bif_a.owner);

        bif_a.cpu_address = 16'h1234; bif_a.cpu_ram_cs_n = 0;
        #1;
        expect_val("run_address", 16'h1234); observe(bif_a.address);
        expect_val("run_ram_cs_n", 0);        observe(bif_a.ram_cs_n);
        expect_val("run_eeprom_cs_n", 1);     observe(bif_a.eeprom_cs_n);
        expect_val("run_eeprom_oe_n", 1);     observe(bif_a.eeprom_oe_n);

        // external grant handshake
        bif_a.ext_address = 16'h0042; bif_a.ext_ram_we_n = 0; bif_a.ext_ram_cs_n = 0;
        bif_a.ext_req = 1;
        tick();
        expect_val("busreq_n_low", 0);   observe(bif_a.cpu_busreq_n);
        expect_val("busreq_owner", 2);   observe(bif_a.owner);
        expect_val("busreq_grant", 0);   observe(bif_a.ext_grant);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_val("busreq_wait_n", 0);     observe(bif_a.cpu_busreq_n);
            expect_val("busreq_wait_grant", 0); observe(bif_a.ext_grant);
        end
        bif_a.cpu_busack_n = 0;
        tick();
        expect_val("ext_grant", 1);         observe(bif_a.ext_grant);
        expect_val("ext_owner", 3);         observe(bif_a.owner);
        expect_val("ext_address", 16'h0042); observe(bif_a.address);
        expect_val("ext_ram_we_n", 0);      observe(bif_a.ram_we_n);
        expect_val("ext_eeprom_oe_n", 1);   observe(bif_a.eeprom_oe_n);
        bif_a.ext_req = 0;
        tick();
        expect_val("release_grant", 0);     observe(bif_a.ext_grant);
        expect_val("release_busreq_n", 1);  observe(bif_a.cpu_busreq_n);
        expect_val("release_owner", 0);     observe(bif_a.owner);
        tick(); tick();
        expect_val("release_hold_owner", 0); observe(bif_a.owner);
        bif_a.cpu_busack_n = 1;
        tick();
        expect_val("rerun_owner", 2);       observe(bif_a.owner);

        // abort before acknowledge
        bif_a.ext_req = 1;
        tick();
        expect_val("abort_busreq_n_low", 0); observe(bif_a.cpu_busreq_n);
        bif_a.ext_req = 0;
        tick();
        expect_val("abort_busreq_n", 1);     observe(bif_a.cpu_busreq_n);
        expect_val("abort_owner", 0);        observe(bif_a.owner);
        expect_val("abort_grant", 0);        observe(bif_a.ext_grant);
        tick();
        expect_val("abort_rerun_owner", 2);  observe(bif_a.owner);
        expect_val("abort_rerun_grant", 0);  observe(bif_a.ext_grant);

        // reset while the external requester holds the bus
        bif_a.ext_req = 1;
        tick();
        bif_a.cpu_busack_n = 0;
        tick();
        expect_val("midgrant_grant", 1);     observe(bif_a.ext_grant);
        reset_a = 1;
        tick();
        expect_val("midrst_grant", 0);       observe(bif_a.ext_grant);
        expect_val("midrst_owner", 0);       observe(bif_a.owner);
        expect_val("midrst_cpu_reset_n", 0); observe(bif_a.cpu_reset_n);
        expect_val("midrst_busreq_n", 1);    observe(bif_a.cpu_busreq_n);
        expect_val("midrst_boot_done", 0);   observe(bif_a.boot_done);
        expect_val("midrst_address", 0);     observe(bif_a.address);

        // copy timeout of 50 cycles
        reset_b = 0;
        n = 0;
        seen = 0;
        while (n < 200 && !seen) begin
            tick();
            n++;
            if (bif_b.fault) seen = 1;
        end
        expect_val("timeout_latency", 51);     observe(n);
        expect_val("timeout_fault", 1);        observe(bif_b.fault);
        expect_val("fault_copier_reset_n", 0); observe(bif_b.copier_reset_n);
        expect_val("fault_cpu_reset_n", 0);    observe(bif_b.cpu_reset_n);
        expect_val("fault_owner", 0);          observe(bif_b.owner);
        expect_val("fault_eeprom_cs_n", 1);    observe(bif_b.eeprom_cs_n);
        bif_b.copier_done = 1;
        tick(); tick(); tick();
        expect_val("fault_sticky", 1);         observe(bif_b.fault);
        expect_val("fault_sticky_boot", 0);    observe(bif_b.boot_done);
        reset_b = 1;
        tick();
        expect_val("fault_rst_fault", 0);      observe(bif_b.fault);
        expect_val("fault_rst_copier", 0);     observe(bif_b.copier_reset_n);
        expect_val("fault_rst_owner", 0);      observe(bif_b.owner);

        // timeout disabled, very long copy
        reset_c = 0;
        tick();
        any_fault = 0;
        for (int i = 0; i < 60000; i++) begin
            tick();
            if (bif_c.fault) any_fault = 1;
        end
        expect_val("notimeout_fault", 0);  observe(any_fault);
        expect_val("notimeout_owner", 1);  observe(bif_c.owner);
        bif_c.copier_done = 1;
        tick();
        bif_c.copier_done = 0;
        n = 0;
        while (n < 20 && !bif_c.boot_done) begin
            tick();
            n++;
        end
        expect_val("notimeout_delay", 4);     observe(n);
        expect_val("notimeout_cpu_reset", 1); observe(bif_c.cpu_reset_n);
        expect_val("notimeout_run_owner", 2); observe(bif_c.owner);
        expect_val("notimeout_fault_end", 0); observe(bif_c.fault);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_bus_sequencer.md
Name: boot_bus_sequencer

Overview:
- Sequences the bootstrap memory system and owns the shared address/RAM/EEPROM bus.
- After reset, holds the CPU in reset and releases the EEPROM-to-RAM copier. It hands the bus to the copier until the copier reports done, waits a settle delay, then releases the CPU.
- In run mode, arbitrates the bus between the CPU and an external loader/debug requester using the CPU's bus-request/bus-acknowledge handshake.

Parameters:
- CPU_RESET_DELAY, 16: cycles between copier done and CPU reset release; must be ≥1.
- COPY_TIMEOUT, 40000: maximum cycles allowed in COPY before entering FAULT; 0 disables the timeout.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- copier_reset_n  out  1  copier reset (active low).
- copier_done  in  1  copier finished flag.
- copier_address  in  16  copier bus address.
- copier_ram_we_n / copier_ram_cs_n / copier_eeprom_oe_n / copier_eeprom_cs_n  in  1 each  copier strobes.
- cpu_reset_n  out  1  CPU reset (active low).
- cpu_busreq_n  out  1  bus request to CPU (active low).
- cpu_busack_n  in  1  CPU bus acknowledge (active low).
- cpu_address  in  16  CPU address.
- cpu_ram_we_n / cpu_ram_cs_n  in  1 each  CPU RAM strobes.
- ext_req  in  1  external requester wants the bus.
- ext_grant  out  1  external requester owns the bus.
- ext_address  in  16  external address.
- ext_ram_we_n / ext_ram_cs_n  in  1 each  external RAM strobes.
- address  out  16  shared bus address.
- ram_we_n / ram_cs_n / eeprom_oe_n / eeprom_cs_n  out  1 each  shared bus strobes.
- owner  out  2  current bus owner: 0 none, 1 copier, 2 cpu, 3 ext.
- boot_done  out  1  high from RUN onward.
- fault  out  1  copy timeout occurred.

Behaviour:
- Clock is `clock`. Reset is `reset`: synchronous, active-high.
- States and the registers they drive:
  - HOLD: copier_reset_n=0, owner=none.
  - COPY: copier_reset_n=1, owner=copier.
  - HANDOFF: owner=none, delay counter running.
  - RUN: owner=cpu, cpu_reset_n=1.
  - BUSREQ: cpu_busreq_n=0, owner=cpu.
  - EXT: ext_grant=1, owner=ext.
  - RELEASE: owner=none, cpu_busreq_n=1.
  - FAULT: owner=none, fault=1.
- Reset values (state HOLD): copier_reset_n=0, cpu_reset_n=0, cpu_busreq_n=1, ext_grant=0, owner=0, boot_done=0, fault=0.
- Reset takes effect from any state, including mid-copy or mid-grant.
- Control outputs (copier_reset_n, cpu_reset_n, cpu_busreq_n, ext_grant, owner, boot_done, fault) are registered.
- Bus outputs are a combinational mux on registered owner:
  - copier: all five copier signals pass through.
  - cpu / ext: selected address and RAM strobes pass through; eeprom_oe_n=1, eeprom_cs_n=1.
  - none: address=16'h0000 and all strobes=1 (idle).
- Transitions:
  - HOLD→COPY: unconditionally after one cycle; timeout counter cleared.
  - COPY→HANDOFF: on copier_done=1; counter loaded with CPU_RESET_DELAY.
  - COPY→FAULT: COPY_TIMEOUT≠0 and COPY_TIMEOUT cycles elapse without copier_done. copier_done takes priority when it coincides with the timeout cycle.
  - HANDOFF: decrements each cycle. When the counter reaches 1, next state is RUN, with cpu_reset_n=1 and boot_done=1.
  - Resulting latency: copier_done sampled high → cpu_reset_n high exactly CPU_RESET_DELAY cycles later.
  - RUN→BUSREQ: when ext_req=1.
  - BUSREQ→EXT: when cpu_busack_n=0 and ext_req=1.
  - BUSREQ→RELEASE: if ext_req falls before acknowledge (abort).
  - EXT→RELEASE: when ext_req=0. ext_grant falls the same edge; cpu_busreq_n=1.
  - RELEASE→RUN: when cpu_busack_n=1. Stays in RELEASE while ack is held.
  - FAULT: terminal until reset. copier and CPU held in reset.
- Requester rules:
  - ext_req is ignored in HOLD, COPY, HANDOFF and FAULT; grant is never given before boot_done.
  - ext_req must stay high until ext_grant; dropping it earlier is a legal abort.
- Counter widths: $clog2(parameter+1), minimum 1 bit. No wrap; the timeout counter saturates.

Test Plan:
- Boot, normal case: CPU_RESET_DELAY=4, copier model asserts done at cycle 100 → owner=1 cycles 2..100; owner=0 for 4 cycles; cpu_reset_n=1 and boot_done=1 exactly 4 cycles after done sampled; owner=2.
- Bus mux: in COPY with copier_address=16'hE123 and copier_ram_we_n=0 → address=16'hE123, ram_we_n=0. In RUN with CPU address 16'h1234 → address=16'h1234 and eeprom_cs_n=1.
- External grant: ext_req=1 in RUN → cpu_busreq_n=0 next cycle; busack_n=0 after 3 cycles → ext_grant=1 and address follows ext_address=16'h0042. Drop ext_req → grant=0 next cycle; busreq_n=1; RUN only after busack_n=1.
- Abort and early request: ext_req held high during COPY → no grant before boot_done. Pulse ext_req in RUN and drop before ack → RELEASE, no ext_grant ever.
- Timeout: COPY_TIMEOUT=50, copier_done never asserted → fault=1 after 50 COPY cycles; cpu_reset_n=0 and copier_reset_n=0 held; reset returns all outputs to reset values.
- Timeout disabled: COPY_TIMEOUT=0 with done at cycle 60000 → no fault; normal boot completes.
